mfp_adc_max10_sequencer: RTL and testbench
==========================================

Name: mfp_adc_max10_sequencer

Overview:
Scan sequencer for the MAX10 modular ADC Avalon-ST command/response interface. Walks a latched channel mask and issues one conversion command per enabled channel, lowest index first. Stores each 12-bit result in a per-channel register file and raises a sticky scan-done interrupt. Sits between the AHB-Lite register block (config, start, result readout) and the Altera ADC IP core.

Parameters:
CH_COUNT, 9, number of channels scanned; mask bit i maps to ADC channel i (5-bit channel code)
TIMEOUT_CYCLES, 1023, max HCLK cycles waiting for a response before abort; counter width = $clog2(TIMEOUT_CYCLES+1)

Ports:
HCLK  in  1  system clock (ADC IP clock_clk domain)
HRESETn  in  1  asynchronous active-low reset
cfg_mask  in  CH_COUNT  channels to scan
cfg_continuous  in  1  1 = restart scan after each completion
cfg_trig_en  in  1  allow ADC_Trigger to start a scan
start  in  1  single-cycle scan request
ADC_Trigger  in  1  external level trigger, rising edge detected internally
irq_ack  in  1  clears done_irq and error flags
rd_index  in  $clog2(CH_COUNT)  result register select
rd_data  out  12  result[rd_index], combinational
result_fresh  out  CH_COUNT  bit i set when result[i] was written in current/last scan
busy  out  1  FSM not IDLE
ADC_Interrupt  out  1  sticky scan-done flag
err_channel  out  1  sticky: response channel mismatch or stray response
err_timeout  out  1  sticky: response timeout
ADC_C_Valid / ADC_C_Channel[4:0] / ADC_C_SOP / ADC_C_EOP  out  command stream
ADC_C_Ready  in  1  command ready
ADC_R_Valid / ADC_R_Channel[4:0] / ADC_R_Data[11:0] / ADC_R_SOP / ADC_R_EOP  in  response stream (SOP/EOP ignored)

Behaviour:
- Reset: all outputs 0, result regs 0, FSM IDLE, trigger-edge register 0.
- States: IDLE, ISSUE, WAIT.
- IDLE: go = start | (cfg_trig_en & ADC_Trigger rising edge). If go & cfg_mask!=0: latch mask into scan_mask, clear result_fresh, idx = lowest set bit, first=1 -> ISSUE. go with mask==0: ignored, no irq. go while busy: ignored.
- ISSUE: ADC_C_Valid=1, ADC_C_Channel=idx; SOP=first; EOP=1 when no set scan_mask bit above idx. Command stays stable until ADC_C_Valid&ADC_C_Ready, then -> WAIT, first=0, timeout counter cleared.
- WAIT: at most one outstanding command. On ADC_R_Valid: if ADC_R_Channel==idx, result[idx]<=ADC_R_Data and result_fresh[idx]<=1; else err_channel<=1 and data dropped. Either way: if more mask bits -> idx=next set bit, ISSUE; else ADC_Interrupt<=1, then ISSUE with lowest bit and first=1 if cfg_continuous, else IDLE.
- Timeout: counter increments each WAIT cycle; at TIMEOUT_CYCLES with no response -> err_timeout<=1, IDLE, no done irq.
- ADC_R_Valid outside WAIT: err_channel<=1, ignored.
- cfg_mask changes mid-scan do not affect the current scan; cfg_continuous is sampled at scan end (clearing it stops after current scan).
- irq_ack clears ADC_Interrupt, err_channel, err_timeout; if a set event occurs in the same cycle, set wins.
- Latency: command issued the cycle after go; done irq visible the cycle after the last accepted response.

Optional Feature:
ADC_SEQ_AVG_EN: when defined, each channel is converted 4 times back-to-back. Responses are summed into a 14-bit accumulator and result = sum[13:2]. SOP is on the first command of the scan, EOP on the 4th command of the last channel. A channel mismatch on any of the 4 samples drops that channel's result (result_fresh stays 0) and sets err_channel. When not defined: one conversion per channel, as above.

Test Plan:
- mask=0x005, start pulse, Ready=1, responses ch0=0x123 then ch2=0xABC -> commands ch0 (SOP=1,EOP=0), ch2 (SOP=0,EOP=1); result[0]=0x123, result[2]=0xABC, result_fresh=0x005, ADC_Interrupt=1, busy=0.
- Ready held 0 for 5 cycles in ISSUE -> Valid/Channel/SOP/EOP stable for all 5 cycles, single command on Ready.
- mask=0x001, response carrying channel 3 -> err_channel=1, result[0] unchanged, ADC_Interrupt=1; irq_ack -> both clear.
- mask=0x002, no response, TIMEOUT_CYCLES=15 -> err_timeout=1 after 15 WAIT cycles, IDLE, ADC_Interrupt=0.
- cfg_continuous=1, mask=0x003 -> back-to-back scans with SOP on ch0 each scan; cfg_continuous->0 mid-scan -> IDLE after ch1.
- cfg_trig_en=1, ADC_Trigger held high 10 cycles -> exactly one scan; HRESETn asserted in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/mfp_adc_max10_sequencer.sv
// Scan sequencer for the MAX10 modular ADC command/response streams; one outstanding conversion,
// results held per channel. Optional build macro ADC_SEQ_AVG_EN averages 4 conversions per channel.
module mfp_adc_max10_sequencer #(
    parameter int CH_COUNT       = 9,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [CH_COUNT-1:0]         cfg_mask,
    input  logic                        cfg_continuous,
    input  logic                        cfg_trig_en,
    input  logic                        start,
    input  logic                        ADC_Trigger,
    input  logic                        irq_ack,
    input  logic [$clog2(CH_COUNT)-1:0] rd_index,
    output logic [11:0]                 rd_data,
    output logic [CH_COUNT-1:0]         result_fresh,
    output logic                        busy,
    output logic                        ADC_Interrupt,
    output logic                        err_channel,
    output logic                        err_timeout,
    output logic                        ADC_C_Valid,
    output logic [4:0]                  ADC_C_Channel,
    output logic                        ADC_C_SOP,
    output logic                        ADC_C_EOP,
    input  logic                        ADC_C_Ready,
    input  logic                        ADC_R_Valid,
    input  logic [4:0]                  ADC_R_Channel,
    input  logic [11:0]                 ADC_R_Data,
    input  logic                        ADC_R_SOP,
    input  logic                        ADC_R_EOP
);
    localparam int IW = $clog2(CH_COUNT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  trig_q;
    logic [CH_COUNT-1:0]   mask_q, mask_d, fresh_q, fresh_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  first_q, first_d, irq_q, irq_d;
    logic                  errc_q, errc_d, errt_q, errt_d;
    logic [11:0]           res_q [CH_COUNT];
    logic                  wr_en, step, go, more, ch_match;
    logic [11:0]           wr_dat;
    logic                  unused_sop_eop;
`ifdef ADC_SEQ_AVG_EN
    logic [1:0]            rep_q, rep_d;
    logic [13:0]           acc_q, acc_d, acc_sum;
    logic                  bad_q, bad_d;
`endif

    function automatic logic [IW-1:0] lowest_from(input logic [CH_COUNT-1:0] m, input int from);
        logic [IW-1:0] r;
        r = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--)
            if (i >= from && m[i]) r = IW'(i);
        return r;
    endfunction

    assign unused_sop_eop = ADC_R_SOP ^ ADC_R_EOP;
    assign go       = start | (cfg_trig_en & ADC_Trigger & ~trig_q);
    assign ch_match = (ADC_R_Channel == 5'(idx_q));

    always_comb begin
        more = 1'b0;
        for (int i = 0; i < CH_COUNT; i++)
            if (i > int'(idx_q) && mask_q[i]) more = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            mask_q  <= '0;
            fresh_q <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            first_q <= 1'b0;
            irq_q   <= 1'b0;
            errc_q  <= 1'b0;
            errt_q  <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) res_q[i] <= '0;
`ifdef ADC_SEQ_AVG_EN
            rep_q   <= '0;
            acc_q   <= '0;
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            trig_q  <= ADC_Trigger;
            mask_q  <= mask_d;
            fresh_q <= fresh_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            first_q <= first_d;
            irq_q   <= irq_d;
            errc_q  <= errc_d;
            errt_q  <= errt_d;
            if (wr_en) res_q[idx_q] <= wr_dat;
`ifdef ADC_SEQ_AVG_EN
            rep_q   <= rep_d;
            acc_q   <= acc_d;
            bad_q   <= bad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        fresh_d = fresh_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        first_d = first_q;
        irq_d   = irq_q;
        errc_d  = errc_q;
        errt_d  = errt_q;
        wr_en   = 1'b0;
        wr_dat  = ADC_R_Data;
        step    = 1'b0;
`ifdef ADC_SEQ_AVG_EN
        rep_d   = rep_q;
        acc_d   = acc_q;
        bad_d   = bad_q;
        acc_sum = acc_q + 14'(ADC_R_Data);
`endif
        // Clears first so that any set event below in the same cycle wins.
        if (irq_ack) begin
            irq_d  = 1'b0;
            errc_d = 1'b0;
            errt_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: if (go && (cfg_mask != '0)) begin
                mask_d  = cfg_mask;
                fresh_d = '0;
                idx_d   = lowest_from(cfg_mask, 0);
                first_d = 1'b1;
                state_d = S_ISSUE;
`ifdef ADC_SEQ_AVG_EN
                rep_d   = '0;
                acc_d   = '0;
                bad_d   = 1'b0;
`endif
            end
            S_ISSUE: if (ADC_C_Ready) begin
                first_d = 1'b0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: if (ADC_R_Valid) begin
`ifdef ADC_SEQ_AVG_EN
                if (!ch_match) begin
                    errc_d = 1'b1;
                    bad_d  = 1'b1;
                end
                if (rep_q != 2'd3) begin
                    rep_d   = rep_q + 2'd1;
                    acc_d   = acc_sum;
                    state_d = S_ISSUE;
                end else begin
                    wr_en  = ~bad_d;
                    wr_dat = acc_sum[13:2];
                    if (!bad_d) fresh_d[idx_q] = 1'b1;
                    rep_d  = '0;
                    acc_d  = '0;
                    bad_d  = 1'b0;
                    step   = 1'b1;
                end
`else
                if (ch_match) begin
                    wr_en          = 1'b1;
                    fresh_d[idx_q] = 1'b1;
                end else begin
                    errc_d = 1'b1;
                end
                step = 1'b1;
`endif
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                errt_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (step) begin
            if (more) begin
                idx_d   = lowest_from(mask_q, int'(idx_q) + 1);
                state_d = S_ISSUE;
            end else begin
                irq_d = 1'b1;
                if (cfg_continuous) begin
                    idx_d   = lowest_from(mask_q, 0);
                    first_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
        if (ADC_R_Valid && state_q != S_WAIT) errc_d = 1'b1;
    end

    always_comb begin
        ADC_C_Valid   = (state_q == S_ISSUE);
        ADC_C_Channel = 5'(idx_q);
        ADC_C_SOP     = ADC_C_Valid & first_q;
`ifdef ADC_SEQ_AVG_EN
        ADC_C_EOP     = ADC_C_Valid & ~more & (rep_q == 2'd3);
`else
        ADC_C_EOP     = ADC_C_Valid & ~more;
`endif
        busy          = (state_q != S_IDLE);
        ADC_Interrupt = irq_q;
        err_channel   = errc_q;
        err_timeout   = errt_q;
        result_fresh  = fresh_q;
        rd_data       = '0;
        for (int i = 0; i < CH_COUNT; i++)
            if (rd_index == IW'(i)) rd_data = res_q[i];
    end
endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Randomized scoreboard bench for the ADC scan sequencer (default build, short timeout).
module tb_mfp_adc_max10_sequencer;
    localparam int CH  = 9;
    localparam int TMO = 15;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [CH-1:0] cfg_mask = '0;
    logic        cfg_continuous = 1'b0, cfg_trig_en = 1'b0, start = 1'b0;
    logic        ADC_Trigger = 1'b0, irq_ack = 1'b0;
    logic [3:0]  rd_index = '0;
    logic [11:0] rd_data;
    logic [CH-1:0] result_fresh;
    logic        busy, ADC_Interrupt, err_channel, err_timeout;
    logic        ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_C_Ready;
    logic [4:0]  ADC_C_Channel;
    logic        ADC_R_Valid, ADC_R_SOP, ADC_R_EOP;
    logic [4:0]  ADC_R_Channel;
    logic [11:0] ADC_R_Data;

    mfp_adc_max10_sequencer #(.CH_COUNT(CH), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .cfg_mask(cfg_mask), .cfg_continuous(cfg_continuous),
        .cfg_trig_en(cfg_trig_en), .start(start), .ADC_Trigger(ADC_Trigger), .irq_ack(irq_ack),
        .rd_index(rd_index), .rd_data(rd_data), .result_fresh(result_fresh), .busy(busy),
        .ADC_Interrupt(ADC_Interrupt), .err_channel(err_channel), .err_timeout(err_timeout),
        .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel), .ADC_C_SOP(ADC_C_SOP),
        .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready), .ADC_R_Valid(ADC_R_Valid),
        .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data), .ADC_R_SOP(ADC_R_SOP),
        .ADC_R_EOP(ADC_R_EOP));

    initial forever #5 HCLK = ~HCLK;

    typedef struct packed {logic [4:0] sent; logic [4:0] want; logic [11:0] dat;} rsp_t;
    logic [6:0] exp_cmd[$];      // {channel, sop, eop}
    int         resp_q[$];
    rsp_t       rsp_log[$];
    int tests = 0, fails = 0, cmd_cnt = 0;
    int ready_mode = 0;          // 0: always ready, 1: random, 2: held low
    int bad_pct = 0;
    bit no_resp = 1'b0;
    logic [11:0] model_res [CH];
    logic [CH-1:0] model_fresh;
    logic model_errc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a scan is the ascending list of set mask bits, SOP on the first, EOP on the last.
    task automatic push_scan(input logic [CH-1:0] m);
        int cnt, seen;
        cnt = $countones(m);
        seen = 0;
        for (int i = 0; i < CH; i++)
            if (m[i]) begin
                exp_cmd.push_back({5'(i), seen == 0, seen == cnt - 1});
                seen++;
            end
    endtask

    initial forever begin
        @(negedge HCLK);
        if (HRESETn && ADC_C_Valid && ADC_C_Ready) begin
            cmd_cnt++;
            if (exp_cmd.size() == 0) chk("cmd_extra", exp_cmd.size(), 1);
            else chk("cmd", {ADC_C_Channel, ADC_C_SOP, ADC_C_EOP}, exp_cmd.pop_front());
            resp_q.push_back(int'(ADC_C_Channel));
        end
    end

    initial forever begin
        ADC_C_Ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge HCLK); #1;
    end

    initial begin
        int dly, want;
        logic [4:0] sent;
        logic [11:0] d;
        dly = 0;
        ADC_R_Valid = 1'b0; ADC_R_Channel = '0; ADC_R_Data = '0; ADC_R_SOP = 1'b1; ADC_R_EOP = 1'b1;
        forever begin
            @(posedge HCLK); #1;
            ADC_R_Valid = 1'b0;
            if (resp_q.size() != 0) begin
                if (dly != 0) dly--;
                else begin
                    want = resp_q.pop_front();
                    dly = $urandom_range(0, 3);
                    if (!no_resp) begin
                        sent = ($urandom_range(0, 99) < bad_pct) ? (5'(want) ^ 5'd3) : 5'(want);
                        d = 12'($urandom);
                        ADC_R_Valid = 1'b1; ADC_R_Channel = sent; ADC_R_Data = d;
                        rsp_log.push_back({sent, 5'(want), d});
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge HCLK); #1 start = 1'b1;
        @(posedge HCLK); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin @(negedge HCLK); n++; end while (busy && n < 3000);
        chk({nm, "_idle"}, busy, 0);
    endtask

    task automatic check_scan(input string nm, input logic exp_irq, input logic exp_errt);
        rsp_t r;
        wait_idle(nm);
        while (rsp_log.size() != 0) begin
            r = rsp_log.pop_front();
            if (r.sent == r.want) begin
                model_res[r.want] = r.dat;
                model_fresh[r.want] = 1'b1;
            end else model_errc = 1'b1;
        end
        for (int i = 0; i < CH; i++) begin
            rd_index = 4'(i); #1;
            chk($sformatf("%s_res%0d", nm, i), rd_data, model_res[i]);
        end
        chk({nm, "_fresh"}, result_fresh, model_fresh);
        chk({nm, "_irq"}, ADC_Interrupt, exp_irq);
        chk({nm, "_errc"}, err_channel, model_errc);
        chk({nm, "_errt"}, err_timeout, exp_errt);
        @(posedge HCLK); #1 irq_ack = 1'b1;
        @(posedge HCLK); #1 irq_ack = 1'b0;
        @(negedge HCLK);
        chk({nm, "_ack"}, {ADC_Interrupt, err_channel, err_timeout}, 0);
        model_errc = 1'b0;
    endtask

    task automatic run_scan(input string nm, input logic [CH-1:0] m);
        cfg_mask = m;
        model_fresh = '0;
        push_scan(m);
        pulse_start();
        cfg_mask = CH'($urandom);
        check_scan(nm, 1'b1, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        logic [7:0] snap;
        for (int i = 0; i < CH; i++) model_res[i] = '0;
        model_fresh = '0;
        model_errc = 1'b0;
        #2;
        chk("reset_out", {busy, ADC_C_Valid, ADC_Interrupt, err_channel, err_timeout, result_fresh, rd_data}, 0);
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        run_scan("basic", 9'h005);

        // A start with an empty mask must not start a scan or raise an interrupt.
        cfg_mask = '0;
        pulse_start();
        @(negedge HCLK);
        chk("zero_mask", {busy, ADC_Interrupt}, 0);

        ready_mode = 2;
        cfg_mask = 9'h005;
        model_fresh = '0;
        push_scan(9'h005);
        base = cmd_cnt;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            @(negedge HCLK);
            snap = {ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP};
            chk($sformatf("stall%0d", k), snap, {1'b1, 5'd0, 1'b1, 1'b0});
        end
        ready_mode = 0;
        check_scan("stall", 1'b1, 1'b0);
        chk("stall_cmds", cmd_cnt - base, 2);

        bad_pct = 100;
        run_scan("mismatch", 9'h001);
        bad_pct = 0;

        no_resp = 1'b1;
        cfg_mask = 9'h002;
        push_scan(9'h002);
        pulse_start();
        n = 0;
        for (int k = 0; k < 100 && !err_timeout; k++) begin
            @(negedge HCLK);
            if (busy && !ADC_C_Valid) n++;
        end
        chk("tmo_cycles", n, TMO);
        no_resp = 1'b0;
        model_fresh = '0;
        check_scan("tmo", 1'b0, 1'b1);

        ready_mode = 1;
        bad_pct = 15;
        for (int t = 0; t < 20; t++)
            run_scan($sformatf("rnd%0d", t), CH'($urandom_range(1, (1 << CH) - 1)));
        bad_pct = 0;

        cfg_mask = 9'h003;
        cfg_continuous = 1'b1;
        model_fresh = '0;
        for (int s = 0; s < 3; s++) push_scan(9'h003);
        base = cmd_cnt;
        pulse_start();
        for (int k = 0; k < 500 && cmd_cnt < base + 5; k++) @(negedge HCLK);
        cfg_continuous = 1'b0;
        check_scan("cont", 1'b1, 1'b0);
        chk("cont_cmds", cmd_cnt - base, 6);
        chk("cont_left", exp_cmd.size(), 0);

        ready_mode = 0;
        cfg_mask = 9'h0A0;
        base = cmd_cnt;
        @(posedge HCLK); #1 ADC_Trigger = 1'b1;
        @(posedge HCLK); #1 ADC_Trigger = 1'b0;
        @(negedge HCLK);
        chk("trig_disabled", {busy, 5'(cmd_cnt - base)}, 0);
        cfg_trig_en = 1'b1;
        model_fresh = '0;
        push_scan(9'h0A0);
        @(posedge HCLK); #1 ADC_Trigger = 1'b1;
        repeat (10) @(posedge HCLK);
        #1 ADC_Trigger = 1'b0;
        check_scan("trig", 1'b1, 1'b0);
        chk("trig_cmds", cmd_cnt - base, 2);
        cfg_trig_en = 1'b0;

        no_resp = 1'b1;
        cfg_mask = 9'h1FF;
        push_scan(9'h1FF);
        pulse_start();
        n = 0;
        do begin @(negedge HCLK); n++; end while (!(busy && !ADC_C_Valid) && n < 50);
        chk("rst_in_wait", busy, 1);
        HRESETn = 1'b0;
        #1;
        chk("rst_out", {busy, ADC_C_Valid, ADC_C_SOP, ADC_C_EOP, ADC_Interrupt, err_channel,
                        err_timeout, result_fresh}, 0);
        for (int i = 0; i < CH; i++) begin
            rd_index = 4'(i); #1;
            chk($sformatf("rst_res%0d", i), rd_data, 0);
        end
        repeat (2) @(posedge HCLK);
        exp_cmd.delete();
        resp_q.delete();
        rsp_log.delete();
        #1 HRESETn = 1'b1;
        no_resp = 1'b0;
        for (int i = 0; i < CH; i++) model_res[i] = '0;
        run_scan("post_rst", 9'h111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
